mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_pkg.sv | 58 +++++
 rtl/mcycle_ctrl_if.sv | 42 ++++
 rtl/mcycle_ctrl_timer.sv | 30 +++
 rtl/mcycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared definitions for the multi-cycle processor controller.
//   state_t      : FSM state encoding (also exported on state_o for debug)
//   OP_*         : opcodes decoded in DECODE
//   ALUOP_*      : operation classes sent to the ALU control decoder
//   ctrl_t       : bundle of every control output driven by the FSM
//   is_mem_state : true for states that wait on mem_ready_i
package mcycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] ALUOP_ADD   = 6'b001000;
  localparam logic [5:0] ALUOP_SUB   = 6'b000100;
  localparam logic [5:0] ALUOP_RTYPE = 6'b000000;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [5:0] alu_op;
    logic       illegal;
    logic       timeout;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// mcycle_ctrl_if: bundle of the controller <-> datapath/memory signals.
//   master : controller view (drives enables/selects, samples opcode/flags)
//   slave  : datapath/memory view
// Handshake: mem_read/mem_write are held high by the controller for the
// whole access; the memory completes it by raising mem_ready for one cycle
// in which the enable is high (a ready in the first cycle is a zero-wait
// access). mem_ready outside an access is ignored. If no ready arrives the
// controller abandons the access and raises timeout for one cycle.
interface mcycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [5:0] alu_op;
  logic       illegal;
  logic       timeout;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, iord,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op,
           illegal, timeout, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, iord,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op,
           illegal, timeout, state
  );
endinterface

// File: rtl/mcycle_ctrl_timer.sv
// mem_wait_timer: wait-cycle counter for memory states.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   start   : restart the count (asserted on the cycle the FSM changes state
//             or abandons an access, so the next cycle counts from zero)
//   ready   : memory completion strobe
//   expired : high in the TIMEOUT_CYC-th consecutive cycle with ready low
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt;

  // cnt is the number of cycles already spent in the current state. It
  // cannot run past LAST: expiry forces a restart on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)     cnt <= '0;
    else if (start) cnt <= '0;
    else            cnt <= cnt + 8'd1;
  end

  assign expired = !ready && (cnt == LAST);
endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: control FSM of a multi-cycle MIPS-like processor.
// Inputs : clk_i, rst_i (sync, active-low), opcode_i, zero_i, mem_ready_i.
// Outputs: datapath enables (pc/ir/reg write, mem read/write), mux selects
//          (iord, reg_dst, mem_to_reg, alu_src_a/b, pc_src), alu_op,
//          one-cycle illegal_o/timeout_o pulses, state_o for debug.
// Option : MCYCLE_CTRL_PERF_CNT_EN adds cycle_cnt_o and instr_cnt_o.
// Outputs are decoded from the current state and inputs in the same cycle
// (e.g. ir_write_o follows mem_ready_i in FETCH); all are forced to 0 while
// rst_i is low.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  pc_src_o,
  output logic [5:0]  alu_op_o,
  output logic        illegal_o,
  output logic        timeout_o,
  output logic [3:0]  state_o
`ifdef MCYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o
`endif
);

  state_t state, state_nxt;
  ctrl_t  ctrl, ctrl_out;
  logic   expired, timeout, restart;

  assign timeout = is_mem_state(state) && expired;
  // A timeout in FETCH stays in FETCH, so it must restart the count too.
  assign restart = (state_nxt != state) || timeout;

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .start   (restart),
    .ready   (mem_ready_i),
    .expired (expired)
  );

  always_comb begin
    ctrl      = CTRL_IDLE;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (timeout) begin
          ctrl.timeout = 1'b1;
        end else begin
          ctrl.mem_read = 1'b1;
          if (mem_ready_i) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op    = ALUOP_ADD;
            state_nxt      = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched.
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode_i)
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_I_EXEC;
          default: begin
            ctrl.illegal = 1'b1;
            state_nxt    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
        state_nxt      = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (timeout) begin
          ctrl.timeout = 1'b1;
          state_nxt    = S_FETCH;
        end else begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
          if (mem_ready_i) state_nxt = S_MEM_WB;
        end
      end
      S_MEM_WR: begin
        // The abandoned cycle drops mem_write so no late write can land.
        if (timeout) begin
          ctrl.timeout = 1'b1;
          state_nxt    = S_FETCH;
        end else begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
          if (mem_ready_i) state_nxt = S_FETCH;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
        state_nxt      = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
        state_nxt      = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.pc_write  = zero_i;
        state_nxt      = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
        state_nxt     = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= S_FETCH;
    else        state <= state_nxt;
  end

  assign ctrl_out     = rst_i ? ctrl : CTRL_IDLE;
  assign pc_write_o   = ctrl_out.pc_write;
  assign ir_write_o   = ctrl_out.ir_write;
  assign reg_write_o  = ctrl_out.reg_write;
  assign mem_read_o   = ctrl_out.mem_read;
  assign mem_write_o  = ctrl_out.mem_write;
  assign iord_o       = ctrl_out.iord;
  assign reg_dst_o    = ctrl_out.reg_dst;
  assign mem_to_reg_o = ctrl_out.mem_to_reg;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign pc_src_o     = ctrl_out.pc_src;
  assign alu_op_o     = ctrl_out.alu_op;
  assign illegal_o    = ctrl_out.illegal;
  assign timeout_o    = ctrl_out.timeout;
  assign state_o      = rst_i ? state : 4'd0;

`ifdef MCYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  logic        retire;

  // An instruction retires when a completing state hands back to FETCH;
  // illegal-opcode and timeout exits do not count.
  assign retire = (state != S_FETCH) && (state_nxt == S_FETCH) &&
                  !timeout && !ctrl.illegal;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt_o = rst_i ? cycle_cnt : 32'd0;
  assign instr_cnt_o = rst_i ? instr_cnt : 32'd0;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed, table-driven bench for mcycle_ctrl with
// TIMEOUT_CYC=4. Inputs change on the falling edge; outputs are compared
// 1 ns later, before the next rising edge.
module tb_mcycle_ctrl;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;
  localparam logic [5:0] A_ADD = 6'b001000, A_SUB = 6'b000100, A_RT = 6'b000000;

  // Expected control word: {pcw,irw,rw,mr,mw,iord,rdst,m2r,asa,asb,pcs,aop,ill,to}
  localparam logic [20:0] PCW  = 21'h100000, IRW = 21'h080000, RW  = 21'h040000;
  localparam logic [20:0] MR   = 21'h020000, MW  = 21'h010000, IOD = 21'h008000;
  localparam logic [20:0] RDST = 21'h004000, M2R = 21'h002000, ASA = 21'h001000;
  localparam logic [20:0] ILL  = 21'h000002, TO  = 21'h000001;

  function automatic logic [20:0] asb(input logic [1:0] v); return 21'(v) << 10; endfunction
  function automatic logic [20:0] pcs(input logic [1:0] v); return 21'(v) << 8;  endfunction
  function automatic logic [20:0] aop(input logic [5:0] v); return 21'(v) << 2;  endfunction

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [20:0] ctl;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;
  logic [20:0] dut_ctl;
  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];

  mcycle_ctrl_if bus();

`ifdef MCYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mcycle_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .opcode_i     (bus.opcode),
    .zero_i       (bus.zero),
    .mem_ready_i  (bus.mem_ready),
    .pc_write_o   (bus.pc_write),
    .ir_write_o   (bus.ir_write),
    .reg_write_o  (bus.reg_write),
    .mem_read_o   (bus.mem_read),
    .mem_write_o  (bus.mem_write),
    .iord_o       (bus.iord),
    .reg_dst_o    (bus.reg_dst),
    .mem_to_reg_o (bus.mem_to_reg),
    .alu_src_a_o  (bus.alu_src_a),
    .alu_src_b_o  (bus.alu_src_b),
    .pc_src_o     (bus.pc_src),
    .alu_op_o     (bus.alu_op),
    .illegal_o    (bus.illegal),
    .timeout_o    (bus.timeout),
    .state_o      (bus.state)
`ifdef MCYCLE_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt_o  (cycle_cnt),
    .instr_cnt_o  (instr_cnt)
`endif
  );

  assign dut_ctl = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                    bus.mem_write, bus.iord, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_op,
                    bus.illegal, bus.timeout};

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic [5:0] op, input logic z,
                     input logic [3:0] st, input logic [20:0] ctl, input string name);
    vec_t v;
    v.rdy = rdy; v.op = op; v.z = z; v.st = st; v.ctl = ctl; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge and compare the outputs.
  task automatic step(input vec_t v);
    @(negedge clk);
    bus.mem_ready = v.rdy;
    bus.opcode    = v.op;
    bus.zero      = v.z;
    #1;
    check({v.name, ".state"}, 32'(bus.state), 32'(v.st));
    check({v.name, ".ctl"}, 32'(dut_ctl), 32'(v.ctl));
  endtask

  task automatic step_in(input logic rdy, input logic [5:0] op, input logic z,
                         input logic [3:0] st, input logic [20:0] ctl, input string name);
    vec_t v;
    v.rdy = rdy; v.op = op; v.z = z; v.st = st; v.ctl = ctl; v.name = name;
    step(v);
  endtask

  initial begin
    logic [20:0] f_ok, dec, addr;
    f_ok = PCW | IRW | MR | asb(2'b01) | aop(A_ADD);
    dec  = asb(2'b11) | aop(A_ADD);
    addr = ASA | asb(2'b10) | aop(A_ADD);

    // lw, zero wait: states 0,1,2,3,4
    add(1, LW, 0, 4'd0, f_ok, "lw_fetch");
    add(1, LW, 0, 4'd1, dec, "lw_decode");
    add(0, LW, 0, 4'd2, addr, "lw_addr");
    add(1, LW, 0, 4'd3, IOD | MR, "lw_rd");
    add(0, LW, 0, 4'd4, RW | M2R, "lw_wb");
    // one fetch wait, then sw with ready delayed 3 cycles (write held 4)
    add(0, SW, 0, 4'd0, MR, "sw_fetch_wait");
    add(1, SW, 0, 4'd0, f_ok, "sw_fetch");
    add(1, SW, 0, 4'd1, dec, "sw_decode");
    add(1, SW, 0, 4'd2, addr, "sw_addr");
    add(0, SW, 0, 4'd5, IOD | MW, "sw_wr_w1");
    add(0, SW, 0, 4'd5, IOD | MW, "sw_wr_w2");
    add(0, SW, 0, 4'd5, IOD | MW, "sw_wr_w3");
    add(1, SW, 0, 4'd5, IOD | MW, "sw_wr_done");
    // R-type
    add(1, RT, 0, 4'd0, f_ok, "r_fetch");
    add(0, RT, 0, 4'd1, dec, "r_decode");
    add(1, RT, 0, 4'd6, ASA | aop(A_RT), "r_exec");
    add(0, RT, 0, 4'd7, RW | RDST, "r_wb");
    // addi
    add(1, ADDI, 0, 4'd0, f_ok, "addi_fetch");
    add(0, ADDI, 0, 4'd1, dec, "addi_decode");
    add(0, ADDI, 0, 4'd10, addr, "addi_exec");
    add(0, ADDI, 0, 4'd11, RW, "addi_wb");
    // beq taken / not taken
    add(1, BEQ, 1, 4'd0, f_ok, "beq1_fetch");
    add(0, BEQ, 1, 4'd1, dec, "beq1_decode");
    add(0, BEQ, 1, 4'd8, PCW | ASA | pcs(2'b01) | aop(A_SUB), "beq1_branch");
    add(1, BEQ, 0, 4'd0, f_ok, "beq0_fetch");
    add(0, BEQ, 0, 4'd1, dec, "beq0_decode");
    add(1, BEQ, 0, 4'd8, ASA | pcs(2'b01) | aop(A_SUB), "beq0_branch");
    // jump
    add(1, J, 0, 4'd0, f_ok, "j_fetch");
    add(0, J, 0, 4'd1, dec, "j_decode");
    add(1, J, 0, 4'd9, PCW | pcs(2'b10), "j_jump");
    // illegal opcode: pulse in DECODE, no writes, back to FETCH
    add(1, BAD, 0, 4'd0, f_ok, "ill_fetch");
    add(1, BAD, 0, 4'd1, dec | ILL, "ill_decode");
    // fetch never ready: timeout in the 4th wait cycle, ir_write never set
    add(0, RT, 0, 4'd0, MR, "fto_w1");
    add(0, RT, 0, 4'd0, MR, "fto_w2");
    add(0, RT, 0, 4'd0, MR, "fto_w3");
    add(0, RT, 0, 4'd0, TO, "fto_timeout");
    add(0, RT, 0, 4'd0, MR, "fto_retry");
    add(1, RT, 0, 4'd0, f_ok, "fto_fetch");
    add(0, RT, 0, 4'd1, dec, "fto_decode");
    add(0, RT, 0, 4'd6, ASA | aop(A_RT), "fto_exec");
    add(0, RT, 0, 4'd7, RW | RDST, "fto_wb");

    // Reset: outputs gated even with FETCH + ready presented
    rst_i = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = LW;
    bus.zero = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset.state", 32'(bus.state), 32'd0);
    check("reset.ctl", 32'(dut_ctl), 32'd0);
    rst_i = 1'b1;
    bus.mem_ready = 1'b0;
`ifdef MCYCLE_CTRL_PERF_CNT_EN
    check("reset.cycle_cnt", cycle_cnt, 32'd0);
    check("reset.instr_cnt", instr_cnt, 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

`ifdef MCYCLE_CTRL_PERF_CNT_EN
    // 8 completed instructions (illegal and the fetch timeout excluded)
    @(negedge clk);
    #1;
    check("perf.instr_cnt", instr_cnt, 32'd8);
    check("perf.cycle_cnt", cycle_cnt, 32'(vecs.size() + 1));
`endif

    // lw whose read never completes: timeout from MEM_RD, no register write
    step_in(1, LW, 0, 4'd0, f_ok, "rto_fetch");
    step_in(0, LW, 0, 4'd1, dec, "rto_decode");
    step_in(0, LW, 0, 4'd2, addr, "rto_addr");
    step_in(0, LW, 0, 4'd3, IOD | MR, "rto_w1");
    step_in(0, LW, 0, 4'd3, IOD | MR, "rto_w2");
    step_in(0, LW, 0, 4'd3, IOD | MR, "rto_w3");
    step_in(0, LW, 0, 4'd3, TO, "rto_timeout");
    step_in(0, LW, 0, 4'd0, MR, "rto_back_fetch");

    // Reset arriving during a MEM_WR wait
    step_in(1, SW, 0, 4'd0, f_ok, "rwr_fetch");
    step_in(0, SW, 0, 4'd1, dec, "rwr_decode");
    step_in(0, SW, 0, 4'd2, addr, "rwr_addr");
    step_in(0, SW, 0, 4'd5, IOD | MW, "rwr_wait");
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("rwr_reset.state", 32'(bus.state), 32'd0);
    check("rwr_reset.ctl", 32'(dut_ctl), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("rwr_after.state", 32'(bus.state), 32'd0);
    check("rwr_after.ctl", 32'(dut_ctl), 32'(MR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
